// File: rtl/mer_power_accum.sv
// ============================================================================
// Module   : mer_power_accum
// Brief    : Symbol-rate mapper/error power estimator with block averaging.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mer_power_accum #(
  parameter int LOG2_N    = 10,
  parameter int MAP_SHIFT = 18,
  parameter int ERR_SHIFT = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic signed [17:0] mapper_i,
  input  logic signed [17:0] mapper_q,
  input  logic signed [17:0] error_i,
  input  logic signed [17:0] error_q,
  output logic signed [17:0] mapper_power,
  output logic signed [17:0] error_power,
  output logic               power_valid,
  output logic               sat_flag
);

  localparam int AW = 37 + LOG2_N;
  localparam logic [AW-1:0] C_MAX_AVG = AW'(131071);

  typedef enum logic [0:0] {WARMUP = 1'b0, ACCUM = 1'b1} state_t;

  logic signed [35:0] sq_mi_q, sq_mq_q, sq_ei_q, sq_eq_q;
  logic        [36:0] map_sym_q, err_sym_q;
  logic        [36:0] map_sum, err_sum;

  state_t              state_q, state_d;
  logic                warm_q, warm_d;
  logic [LOG2_N-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]       map_acc_q, map_acc_d, err_acc_q, err_acc_d;
  logic [AW-1:0]       map_tot, err_tot, map_avg, err_avg;
  logic                map_sat, err_sat;
  logic signed [17:0]  mapper_power_q, mapper_power_d, error_power_q, error_power_d;
  logic                valid_q, valid_d, sat_q, sat_d;

  // Squares are never negative, so zero-extension into 37 bits is exact.
  assign map_sum = {1'b0, sq_mi_q} + {1'b0, sq_mq_q};
  assign err_sum = {1'b0, sq_ei_q} + {1'b0, sq_eq_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      sq_mi_q   <= '0;
      sq_mq_q   <= '0;
      sq_ei_q   <= '0;
      sq_eq_q   <= '0;
      map_sym_q <= '0;
      err_sym_q <= '0;
    end else if (clk_en) begin
      sq_mi_q   <= 36'(mapper_i) * 36'(mapper_i);
      sq_mq_q   <= 36'(mapper_q) * 36'(mapper_q);
      sq_ei_q   <= 36'(error_i) * 36'(error_i);
      sq_eq_q   <= 36'(error_q) * 36'(error_q);
      map_sym_q <= map_sum >> MAP_SHIFT;
      err_sym_q <= err_sum >> ERR_SHIFT;
    end
  end

  assign map_tot = map_acc_q + {{LOG2_N{1'b0}}, map_sym_q};
  assign err_tot = err_acc_q + {{LOG2_N{1'b0}}, err_sym_q};
  assign map_avg = map_tot >> LOG2_N;
  assign err_avg = err_tot >> LOG2_N;
  assign map_sat = (map_avg > C_MAX_AVG);
  assign err_sat = (err_avg > C_MAX_AVG);

  always_comb begin
    state_d        = state_q;
    warm_d         = warm_q;
    cnt_d          = cnt_q;
    map_acc_d      = map_acc_q;
    err_acc_d      = err_acc_q;
    mapper_power_d = mapper_power_q;
    error_power_d  = error_power_q;
    valid_d        = 1'b0;
    sat_d          = sat_q;
    if (clk_en) begin
      case (state_q)
        WARMUP: begin
          // Two enables prime S1 and S2 before anything is accumulated.
          warm_d = 1'b1;
          if (warm_q) state_d = ACCUM;
        end
        ACCUM: begin
          if (cnt_q == {LOG2_N{1'b1}}) begin
            mapper_power_d = map_sat ? 18'sd131071 : $signed(map_avg[17:0]);
            error_power_d  = err_sat ? 18'sd131071 : $signed(err_avg[17:0]);
            sat_d          = sat_q | map_sat | err_sat;
            valid_d        = 1'b1;
            map_acc_d      = '0;
            err_acc_d      = '0;
            cnt_d          = '0;
          end else begin
            map_acc_d = map_tot;
            err_acc_d = err_tot;
            cnt_d     = cnt_q + LOG2_N'(1);
          end
        end
        default: state_d = WARMUP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= WARMUP;
      warm_q         <= 1'b0;
      cnt_q          <= '0;
      map_acc_q      <= '0;
      err_acc_q      <= '0;
      mapper_power_q <= '0;
      error_power_q  <= '0;
      valid_q        <= 1'b0;
      sat_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      warm_q         <= warm_d;
      cnt_q          <= cnt_d;
      map_acc_q      <= map_acc_d;
      err_acc_q      <= err_acc_d;
      mapper_power_q <= mapper_power_d;
      error_power_q  <= error_power_d;
      valid_q        <= valid_d;
      sat_q          <= sat_d;
    end
  end

  assign mapper_power = mapper_power_q;
  assign error_power  = error_power_q;
  assign power_valid  = valid_q;
  assign sat_flag     = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_mer_power_accum.sv
// ============================================================================
// Module   : tb_mer_power_accum
// Brief    : Directed self-checking bench for mer_power_accum (LOG2_N = 4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mer_power_accum;

  logic               clk = 1'b0;
  logic               reset;
  logic               clk_en;
  logic signed [17:0] mapper_i, mapper_q, error_i, error_q;
  logic signed [17:0] mapper_power, error_power;
  logic               power_valid, sat_flag;

  int n_cmp = 0;
  int n_bad = 0;
  bit alt_mode = 1'b0;
  bit alt_ph   = 1'b0;

  mer_power_accum #(.LOG2_N(4), .MAP_SHIFT(18), .ERR_SHIFT(12)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .clk_en       (clk_en),
    .mapper_i     (mapper_i),
    .mapper_q     (mapper_q),
    .error_i      (error_i),
    .error_q      (error_q),
    .mapper_power (mapper_power),
    .error_power  (error_power),
    .power_valid  (power_valid),
    .sat_flag     (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick(input bit en);
    clk_en = en;
    if (alt_mode && en) begin
      mapper_i = alt_ph ? 18'sd0 : 18'sd32768;
      alt_ph   = ~alt_ph;
    end
    @(posedge clk);
    #1;
  endtask

  // Runs with clk_en high 1 cycle in `period` until power_valid, counting enables.
  task automatic wait_valid(input int period, output int ens);
    int cyc = 0;
    ens = 0;
    while (1) begin
      bit en = ((cyc % period) == 0);
      tick(en);
      if (en) ens++;
      cyc++;
      if (power_valid) break;
      if (cyc > 400) begin
        chk("valid_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic set_data(input int mi, input int mq, input int ei, input int eq);
    mapper_i = 18'(mi);
    mapper_q = 18'(mq);
    error_i  = 18'(ei);
    error_q  = 18'(eq);
  endtask

  initial begin
    int ens;
    logic signed [17:0] held_mp;
    reset  = 1'b1;
    clk_en = 1'b0;
    set_data(0, 0, 0, 0);
    tick(0);
    tick(0);
    reset = 1'b0;
    chk("rst_mp",    mapper_power, 0);
    chk("rst_ep",    error_power,  0);
    chk("rst_valid", power_valid,  0);
    chk("rst_sat",   sat_flag,     0);

    // Constant symbols, continuous enable: first block after 2 warm-up enables.
    set_data(32768, 32768, 1311, 1311);
    wait_valid(1, ens);
    chk("t1_latency", ens, 18);
    chk("t1_mp",  mapper_power, 8192);
    chk("t1_ep",  error_power,  839);
    chk("t1_sat", sat_flag,     0);
    wait_valid(1, ens);
    chk("t1_period", ens, 16);
    chk("t1_mp2", mapper_power, 8192);
    chk("t1_ep2", error_power,  839);

    // Enable 1 cycle in 3: pulse still one clk wide, outputs hold.
    wait_valid(3, ens);
    chk("t2_period", ens, 16);
    chk("t2_mp", mapper_power, 8192);
    chk("t2_ep", error_power,  839);
    held_mp = mapper_power;
    tick(0);
    chk("t2_pulse_w", power_valid, 0);
    tick(1);
    chk("t2_en_novalid", power_valid, 0);
    chk("t2_hold", mapper_power, held_mp);

    // Full-scale mapper saturates; first block after a data change is discarded.
    set_data(-131072, -131072, 0, 0);
    wait_valid(1, ens);
    wait_valid(1, ens);
    chk("t3_mp",  mapper_power, 131071);
    chk("t3_ep",  error_power,  0);
    chk("t3_sat", sat_flag,     1);
    set_data(32768, 32768, 0, 0);
    wait_valid(1, ens);
    wait_valid(1, ens);
    chk("t3_mp2",  mapper_power, 8192);
    chk("t3_sat2", sat_flag,     1);

    // Alternating mapper_i 32768 / 0 with mapper_q = 0: average of 4096 and 0.
    set_data(0, 0, 0, 0);
    alt_mode = 1'b1;
    wait_valid(1, ens);
    wait_valid(1, ens);
    alt_mode = 1'b0;
    chk("t4_mp", mapper_power, 2048);
    chk("t4_ep", error_power,  0);

    // Poison the pipeline, reset mid-block together with clk_en.
    set_data(-131072, -131072, 0, 0);
    for (int i = 0; i < 12; i++) tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("t5_mp",    mapper_power, 0);
    chk("t5_ep",    error_power,  0);
    chk("t5_valid", power_valid,  0);
    chk("t5_sat",   sat_flag,     0);
    set_data(0, 0, 1311, 1311);
    wait_valid(1, ens);
    chk("t5_latency", ens, 18);
    chk("t5_mp2",  mapper_power, 0);
    chk("t5_ep2",  error_power,  839);
    chk("t5_sat2", sat_flag,     0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
